// File: rtl/exmem_pkg.sv
// Shared types for the EX/MEM pipeline stage: the default-width bundle layout
// and the state encoding of the two-entry skid register.
package exmem_pkg;

    localparam int LANES_DEF  = 4;
    localparam int LANE_W_DEF = 12;
    localparam int DATA_W_DEF = LANES_DEF * LANE_W_DEF;
    localparam int REG_AW_DEF = 4;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] a;
        logic [DATA_W_DEF-1:0] wd;
        logic [REG_AW_DEF-1:0] wa3;
        logic [LANES_DEF-1:0]  lane_mask;
        logic                  pcsrc;
        logic                  reg_write;
        logic                  mem_write;
        logic                  mem_to_reg;
    } exmem_bundle_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic valid/ready register with a two-entry skid buffer. The main entry
// drives the outputs; the skid entry absorbs one bundle while downstream stalls.
module pipe_skid_reg
    import exmem_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t  state;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         accept;
    logic         drain;

    // Handshake flags decode only the state register, so in_ready never
    // depends combinationally on out_ready.
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    // NOTE: payload registers are reset along with the state so every output
    // reads 0 out of reset; all state here is updated with non-blocking <=.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q <= in_data;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_q <= in_data;
                    end else if (accept) begin
                        skid_q <= in_data;
                        state  <= TWO;
                    end else if (drain) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/exmem_pipe_stage.sv
// EX/MEM pipeline stage: packs the Execute bundle into a skid register and
// squashes side-effecting control bits when the held bundle is not live.
module exmem_pipe_stage
    import exmem_pkg::*;
#(
    parameter  int LANES  = LANES_DEF,
    parameter  int LANE_W = LANE_W_DEF,
    parameter  int REG_AW = REG_AW_DEF,
    localparam int DATA_W = LANES * LANE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result_e,
    input  logic [DATA_W-1:0] write_data_e,
    input  logic [REG_AW-1:0] wa3_e,
    input  logic [LANES-1:0]  lane_mask_e,
    input  logic              pcsrc_e,
    input  logic              reg_write_e,
    input  logic              mem_write_e,
    input  logic              mem_to_reg_e,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a_m,
    output logic [DATA_W-1:0] wd_m,
    output logic [REG_AW-1:0] wa3_m,
    output logic [LANES-1:0]  lane_mask_m,
    output logic              pcsrc_m,
    output logic              reg_write_m,
    output logic              mem_write_m,
    output logic              mem_to_reg_m
);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] wd;
        logic [REG_AW-1:0] wa3;
        logic [LANES-1:0]  lane_mask;
        logic              pcsrc;
        logic              reg_write;
        logic              mem_write;
        logic              mem_to_reg;
    } bundle_t;

    bundle_t in_b;
    bundle_t held;
    logic    mask_any;

    assign in_b = '{
        a:          alu_result_e,
        wd:         write_data_e,
        wa3:        wa3_e,
        lane_mask:  lane_mask_e,
        pcsrc:      pcsrc_e,
        reg_write:  reg_write_e,
        mem_write:  mem_write_e,
        mem_to_reg: mem_to_reg_e
    };

    pipe_skid_reg #(
        .W($bits(bundle_t))
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (held)
    );

    // A write with no enabled lane is a no-op for both memory and register file.
    assign mask_any     = |held.lane_mask;
    assign a_m          = held.a;
    assign wd_m         = held.wd;
    assign wa3_m        = held.wa3;
    assign lane_mask_m  = held.lane_mask;
    assign mem_to_reg_m = held.mem_to_reg;
    assign pcsrc_m      = out_valid & held.pcsrc;
    assign reg_write_m  = out_valid & held.reg_write & mask_any;
    assign mem_write_m  = out_valid & held.mem_write & mask_any;

endmodule

// File: tb/tb_exmem_pipe_stage.sv
// Self-checking bench for exmem_pipe_stage: directed scenarios then random
// traffic, compared against a bounded in-order queue model of the stage.
module tb_exmem_pipe_stage;
    import exmem_pkg::*;

    localparam int LANES  = LANES_DEF;
    localparam int LANE_W = LANE_W_DEF;
    localparam int REG_AW = REG_AW_DEF;
    localparam int DATA_W = LANES * LANE_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] alu_result_e;
    logic [DATA_W-1:0] write_data_e;
    logic [REG_AW-1:0] wa3_e;
    logic [LANES-1:0]  lane_mask_e;
    logic              pcsrc_e, reg_write_e, mem_write_e, mem_to_reg_e;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] a_m, wd_m;
    logic [REG_AW-1:0] wa3_m;
    logic [LANES-1:0]  lane_mask_m;
    logic              pcsrc_m, reg_write_m, mem_write_m, mem_to_reg_m;

    exmem_pipe_stage #(
        .LANES(LANES), .LANE_W(LANE_W), .REG_AW(REG_AW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result_e(alu_result_e), .write_data_e(write_data_e),
        .wa3_e(wa3_e), .lane_mask_e(lane_mask_e),
        .pcsrc_e(pcsrc_e), .reg_write_e(reg_write_e),
        .mem_write_e(mem_write_e), .mem_to_reg_e(mem_to_reg_e),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_m(a_m), .wd_m(wd_m), .wa3_m(wa3_m), .lane_mask_m(lane_mask_m),
        .pcsrc_m(pcsrc_m), .reg_write_m(reg_write_m),
        .mem_write_m(mem_write_m), .mem_to_reg_m(mem_to_reg_m)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bundles held by the stage, oldest first, at most two.
    exmem_bundle_t mq[$];
    exmem_bundle_t cur;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exmem_bundle_t rand_bundle();
        exmem_bundle_t b;
        logic [63:0]   r1, r2;
        r1 = {$urandom, $urandom};
        r2 = {$urandom, $urandom};
        b.a          = r1[DATA_W-1:0];
        b.wd         = r2[DATA_W-1:0];
        b.wa3        = REG_AW'($urandom);
        b.lane_mask  = LANES'($urandom);
        b.pcsrc      = 1'($urandom);
        b.reg_write  = 1'($urandom);
        b.mem_write  = 1'($urandom);
        b.mem_to_reg = 1'($urandom);
        return b;
    endfunction

    task automatic drive(input bit v, input exmem_bundle_t b);
        in_valid     = v;
        cur          = b;
        alu_result_e = b.a;
        write_data_e = b.wd;
        wa3_e        = b.wa3;
        lane_mask_e  = b.lane_mask;
        pcsrc_e      = b.pcsrc;
        reg_write_e  = b.reg_write;
        mem_write_e  = b.mem_write;
        mem_to_reg_e = b.mem_to_reg;
    endtask

    task automatic check_outputs();
        exmem_bundle_t f;
        check("in_ready", in_ready, mq.size() < 2);
        check("out_valid", out_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            f = mq[0];
            check("a_m", a_m, f.a);
            check("wd_m", wd_m, f.wd);
            check("wa3_m", wa3_m, f.wa3);
            check("lane_mask_m", lane_mask_m, f.lane_mask);
            check("mem_to_reg_m", mem_to_reg_m, f.mem_to_reg);
            check("pcsrc_m", pcsrc_m, f.pcsrc);
            check("reg_write_m", reg_write_m, f.reg_write && (f.lane_mask != 0));
            check("mem_write_m", mem_write_m, f.mem_write && (f.lane_mask != 0));
        end else begin
            check("pcsrc_m_idle", pcsrc_m, 0);
            check("reg_write_m_idle", reg_write_m, 0);
            check("mem_write_m_idle", mem_write_m, 0);
        end
    endtask

    task automatic check_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_a_m", a_m, 0);
        check("rst_wd_m", wd_m, 0);
        check("rst_wa3_m", wa3_m, 0);
        check("rst_lane_mask_m", lane_mask_m, 0);
        check("rst_ctrl", {pcsrc_m, reg_write_m, mem_write_m, mem_to_reg_m}, 0);
    endtask

    // One clock: decide handshakes from the model, advance it at the edge,
    // then compare on the falling edge.
    task automatic cycle(output bit acc);
        bit drn;
        acc = in_valid && (mq.size() < 2) && !flush;
        drn = out_ready && (mq.size() > 0);
        @(posedge clk);
        if (flush) begin
            mq.delete();
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back(cur);
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        exmem_bundle_t b, c;
        bit            acc;

        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0);
        repeat (2) @(negedge clk);
        check_reset();
        rst = 1'b0;
        cycle(acc);

        // Streaming with a known bundle, then sustained random traffic.
        out_ready = 1'b1;
        b = '0;
        b.a = 48'h123456789ABC;
        b.wa3 = 4'd5;
        b.reg_write = 1'b1;
        b.lane_mask = 4'hF;
        drive(1'b1, b);
        cycle(acc);
        check("stream_a", a_m, 48'h123456789ABC);
        check("stream_wa3", wa3_m, 5);
        check("stream_reg_write", reg_write_m, 1);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, rand_bundle());
            cycle(acc);
        end

        // Back-pressure: A in main, B in skid, C held until accepted.
        out_ready = 1'b0;
        drive(1'b1, rand_bundle());
        cycle(acc);
        drive(1'b1, rand_bundle());
        cycle(acc);
        check("bp_in_ready", in_ready, 0);
        c = rand_bundle();
        drive(1'b1, c);
        cycle(acc);
        cycle(acc);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(acc);
            if (acc) drive(1'b0, c);
        end
        check("bp_drained", out_valid, 0);

        // Flush while full with a simultaneous input.
        out_ready = 1'b0;
        drive(1'b1, rand_bundle());
        cycle(acc);
        b = rand_bundle();
        b.mem_write = 1'b1;
        b.lane_mask = 4'hF;
        drive(1'b1, b);
        cycle(acc);
        drive(1'b1, rand_bundle());
        flush = 1'b1;
        cycle(acc);
        flush = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_mem_write", mem_write_m, 0);
        check("flush_in_ready", in_ready, 1);
        drive(1'b0, '0);
        out_ready = 1'b1;
        repeat (3) cycle(acc);

        // Lane-mask gating of write enables.
        b = rand_bundle();
        b.mem_write = 1'b1;
        b.reg_write = 1'b1;
        b.lane_mask = 4'b0000;
        drive(1'b1, b);
        cycle(acc);
        check("mask0_out_valid", out_valid, 1);
        check("mask0_mem_write", mem_write_m, 0);
        check("mask0_reg_write", reg_write_m, 0);
        b.lane_mask = 4'b0101;
        drive(1'b1, b);
        cycle(acc);
        check("mask5_mem_write", mem_write_m, 1);
        check("mask5_lane_mask", lane_mask_m, 4'b0101);
        drive(1'b0, '0);
        cycle(acc);

        // Asynchronous reset while both entries are full.
        out_ready = 1'b0;
        drive(1'b1, rand_bundle());
        cycle(acc);
        drive(1'b1, rand_bundle());
        cycle(acc);
        check("pre_rst_full", in_ready, 0);
        rst = 1'b1;
        drive(1'b0, '0);
        #1;
        check_reset();
        mq.delete();
        @(negedge clk);
        rst = 1'b0;
        cycle(acc);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 24) == 0);
            drive($urandom_range(0, 9) < 7, rand_bundle());
            cycle(acc);
        end
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, '0);
        repeat (3) cycle(acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exmem_pipe_stage.md
Name: exmem_pipe_stage

Overview:
Parametrised EX/MEM pipeline stage for the vector ASIP: carries the ALU result, store data, destination register and control bits from Execute to Memory. Generalises the fixed 48-bit EX/MEM register with configurable lane count and width, a valid/ready handshake, a two-entry skid buffer for back-pressure, synchronous flush, and a full reset of every field. Sits between the ALU/condition stage and the data-memory interface.

Parameters:
LANES, 4, number of vector lanes
LANE_W, 12, bits per lane; DATA_W = LANES*LANE_W (default 48)
REG_AW, 4, register-file address width

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  EX bundle valid
in_ready  out  1  stage can accept this cycle
alu_result_e  in  DATA_W  ALU result / memory address
write_data_e  in  DATA_W  store data
wa3_e  in  REG_AW  destination register
lane_mask_e  in  LANES  per-lane write enable
pcsrc_e, reg_write_e, mem_write_e, mem_to_reg_e  in  1 each  control bits
flush  in  1  squash all held entries
out_valid  out  1  MEM bundle valid
out_ready  in  1  MEM stage consumes bundle
a_m, wd_m  out  DATA_W  registered result / store data
wa3_m  out  REG_AW  destination register
lane_mask_m  out  LANES  lane mask
pcsrc_m, reg_write_m, mem_write_m, mem_to_reg_m  out  1 each  control bits

Behaviour:
- Reset: rst asynchronous, active-high; clock clk. On reset, both entries invalid; every output 0 (a_m, wd_m, wa3_m, lane_mask_m, all control bits, out_valid); in_ready 1 after reset release.
- Storage: main entry (drives outputs) + skid entry. States: EMPTY (none valid), ONE (main valid), TWO (main + skid valid).
- in_ready = !skid_valid (registered; no combinational path from out_ready).
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- EMPTY: accept -> load main, go ONE. Latency exactly 1 cycle from accept to out_valid.
- ONE: accept&drain -> main <= input, stay ONE; accept&!drain -> skid <= input, go TWO; !accept&drain -> EMPTY.
- TWO: drain -> main <= skid, go ONE (input not accepted, in_ready=0); !drain -> hold.
- Order preserved: bundles exit in acceptance order; none dropped or duplicated absent flush.
- flush (synchronous): next cycle both entries invalid, state EMPTY; flush wins over simultaneous accept (input discarded) and drain (drain still counts for the current cycle only).
- Squashing: pcsrc_m, reg_write_m, mem_write_m forced 0 whenever out_valid=0; data fields may hold stale values.
- mem_write_m additionally requires lane_mask_m != 0; all-zero mask -> mem_write_m=0 and reg_write_m=0.
- Widths: no arithmetic; all fields passed unmodified, DATA_W = LANES*LANE_W exact.
- rst mid-operation: all entries cleared immediately regardless of state.

Decomposition:
- Package exmem_pkg: typedef exmem_bundle_t (packed struct of all data/control fields, parametrised via package localparams for default LANES/LANE_W/REG_AW), state enum {EMPTY, ONE, TWO}.
- One sub-module natural: pipe_skid_reg (generic valid/ready two-entry skid register over a packed payload of width W); exmem_pipe_stage wraps it and applies squash/mask gating.

Test Plan:
- Reset: assert rst mid-stream with TWO entries -> next sample out_valid=0, all outputs 0, in_ready=1.
- Streaming: out_ready=1, in_valid=1 with alu_result_e=0x123456789ABC, wa3_e=5, reg_write_e=1 -> one cycle later a_m=0x123456789ABC, wa3_m=5, reg_write_m=1; one bundle per cycle sustained.
- Back-pressure: send A,B,C with out_ready=0 -> A in main, B in skid, in_ready=0, C held by producer; release out_ready -> outputs A,B,C in order, no loss.
- Flush: state TWO plus in_valid=1 and flush=1 -> next cycle out_valid=0, mem_write_m=0, in_ready=1; flushed input never appears.
- Mask gating: mem_write_e=1, reg_write_e=1, lane_mask_e=4'b0000 -> mem_write_m=0, reg_write_m=0 with out_valid=1; lane_mask_e=4'b0101 -> mem_write_m=1, lane_mask_m=4'b0101.
- Parameter sweep: LANES=8, LANE_W=16 (DATA_W=128), REG_AW=5 -> streaming and back-pressure tests pass unchanged.
